// File: rtl/hash_target_check.sv
// Decides whether a 256-bit SHA-256 digest is numerically <= the mining target.
// Words are compared most-significant first, one per cycle, with early exit on the first difference.
module hash_target_check #(
    parameter int unsigned WORDS  = 8,
    parameter int unsigned WORD_W = 32
) (
    input  logic                      clk,
    input  logic                      n_rst,
    input  logic                      flush,
    input  logic                      hash_valid,
    output logic                      hash_ready,
    input  logic [WORDS*WORD_W-1:0]   hash_in,
    input  logic [31:0]               nonce_in,
    input  logic [WORDS*WORD_W-1:0]   target,
    output logic                      result_valid,
    output logic                      result_found,
    output logic [31:0]               result_nonce,
    output logic [31:0]               check_count
);

    localparam int unsigned BUS_W   = WORDS * WORD_W;
    localparam int unsigned IDX_W   = $clog2(WORDS);
    localparam int unsigned NONCE_W = 32;
    localparam int unsigned CNT_W   = 32;

    localparam logic [1:0] IDLE    = 2'd0;
    localparam logic [1:0] COMPARE = 2'd1;
    localparam logic [1:0] DONE    = 2'd2;

    logic [1:0]         state;
    logic [1:0]         state_next;
    logic [IDX_W-1:0]   idx;
    logic [IDX_W-1:0]   idx_next;
    logic [BUS_W-1:0]   hash_q;
    logic [BUS_W-1:0]   target_q;
    logic [NONCE_W-1:0] nonce_q;

    logic               accept;
    logic               finish;
    logic               found_next;

    logic [WORD_W-1:0]  hash_words   [WORDS];
    logic [WORD_W-1:0]  target_words [WORDS];
    logic [WORD_W-1:0]  h_word;
    logic [WORD_W-1:0]  t_word;

    // Split the captured buses into per-word views for indexed selection.
    always_comb begin
        for (int i = 0; i < int'(WORDS); i++) begin
            hash_words[i]   = hash_q[i*WORD_W +: WORD_W];
            target_words[i] = target_q[i*WORD_W +: WORD_W];
        end
    end

    assign h_word = hash_words[idx];
    assign t_word = target_words[idx];

    // Next-state logic; flush overrides every transition and suppresses any result.
    always_comb begin
        state_next = state;
        idx_next   = idx;
        accept     = 1'b0;
        finish     = 1'b0;
        found_next = 1'b0;

        case (state)
            IDLE: begin
                if (hash_valid && hash_ready) begin
                    accept     = 1'b1;
                    idx_next   = IDX_W'(WORDS - 1);
                    state_next = COMPARE;
                end
            end
            COMPARE: begin
                if (h_word < t_word) begin
                    finish     = 1'b1;
                    found_next = 1'b1;
                end else if (h_word > t_word) begin
                    finish     = 1'b1;
                    found_next = 1'b0;
                end else if (idx == '0) begin
                    // Equality on every word counts as meeting the target.
                    finish     = 1'b1;
                    found_next = 1'b1;
                end else begin
                    idx_next = idx - IDX_W'(1);
                end
                if (finish) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase

        if (flush) begin
            state_next = IDLE;
            idx_next   = idx;
            accept     = 1'b0;
            finish     = 1'b0;
        end
    end

    // State register and registered outputs; results land together with entry into DONE.
    always_ff @(posedge clk) begin
        if (!n_rst) begin
            state        <= IDLE;
            idx          <= '0;
            hash_q       <= '0;
            target_q     <= '0;
            nonce_q      <= '0;
            hash_ready   <= 1'b1;
            result_valid <= 1'b0;
            result_found <= 1'b0;
            result_nonce <= '0;
            check_count  <= '0;
        end else begin
            state        <= state_next;
            idx          <= idx_next;
            hash_ready   <= (state_next == IDLE);
            result_valid <= finish;
            if (accept) begin
                hash_q   <= hash_in;
                target_q <= target;
                nonce_q  <= nonce_in;
            end
            if (finish) begin
                result_found <= found_next;
                result_nonce <= nonce_q;
                check_count  <= check_count + CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_hash_target_check.sv
// Directed bench for hash_target_check: stimulus pushes expected results into a
// scoreboard queue; a negedge monitor pops and compares whenever result_valid is seen.
module tb_hash_target_check;

    logic         clk;
    logic         n_rst;
    logic         flush;
    logic         hash_valid;
    logic         hash_ready;
    logic [255:0] hash_in;
    logic [31:0]  nonce_in;
    logic [255:0] target;
    logic         result_valid;
    logic         result_found;
    logic [31:0]  result_nonce;
    logic [31:0]  check_count;

    hash_target_check dut (
        .clk          (clk),
        .n_rst        (n_rst),
        .flush        (flush),
        .hash_valid   (hash_valid),
        .hash_ready   (hash_ready),
        .hash_in      (hash_in),
        .nonce_in     (nonce_in),
        .target       (target),
        .result_valid (result_valid),
        .result_found (result_found),
        .result_nonce (result_nonce),
        .check_count  (check_count)
    );

    typedef struct {
        logic        found;
        logic [31:0] nonce;
        logic [31:0] count;
        int          cyc;
    } exp_t;

    exp_t        sb[$];
    int          asserts = 0;
    int          fails   = 0;
    int          cyc     = 0;
    logic [31:0] cnt_model   = 0;
    logic        held_found  = 1'b0;
    logic [31:0] held_nonce  = 32'd0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        asserts++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: compare each result pulse against the scoreboard, and check hold otherwise.
    always @(negedge clk) begin
        if (n_rst) begin
            if (result_valid) begin
                if (sb.size() == 0) begin
                    check("unexpected_result_valid", 64'(result_valid), 64'd0);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    check("result_found", 64'(result_found), 64'(e.found));
                    check("result_nonce", 64'(result_nonce), 64'(e.nonce));
                    check("check_count", 64'(check_count), 64'(e.count));
                    check("result_latency", 64'(cyc), 64'(e.cyc));
                    held_found = e.found;
                    held_nonce = e.nonce;
                end
            end else begin
                check("result_hold", {31'd0, result_found, result_nonce},
                      {31'd0, held_found, held_nonce});
            end
        end
    end

    // Called at #1 after a posedge; returns at #1 after the posedge following the accept.
    task automatic send(input logic [255:0] h, input logic [255:0] t, input logic [31:0] nonce,
                        input logic found, input int k, input bit push, output int t_acc);
        int n;
        n = 0;
        while (!hash_ready && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        check("ready_before_accept", 64'(hash_ready), 64'd1);
        hash_valid = 1'b1;
        hash_in    = h;
        target     = t;
        nonce_in   = nonce;
        t_acc      = cyc;
        if (push) begin
            exp_t e;
            cnt_model = cnt_model + 32'd1;
            e.found = found;
            e.nonce = nonce;
            e.count = cnt_model;
            e.cyc   = cyc + 1 + k;
            sb.push_back(e);
        end
        @(posedge clk); #1;
        hash_valid = 1'b0;
        // Scramble inputs after the accept: the check must use the captured copies.
        hash_in  = ~h;
        target   = ~t;
        nonce_in = ~nonce;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (sb.size() != 0 && n < 40) begin
            @(posedge clk); #1;
            n++;
        end
        if (sb.size() != 0) begin
            check("drain_timeout", 64'(sb.size()), 64'd0);
            sb.delete();
        end
    endtask

    task automatic idle_cycles(input int n);
        repeat (n) begin
            @(posedge clk); #1;
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [255:0] h;
        logic [255:0] t;
        int           ta;
        int           tb;

        n_rst      = 1'b0;
        flush      = 1'b0;
        hash_valid = 1'b0;
        hash_in    = '0;
        nonce_in   = '0;
        target     = '0;
        repeat (3) @(posedge clk);
        #1;
        check("reset_hash_ready", 64'(hash_ready), 64'd1);
        check("reset_result_valid", 64'(result_valid), 64'd0);
        check("reset_result_found", 64'(result_found), 64'd0);
        check("reset_result_nonce", 64'(result_nonce), 64'd0);
        check("reset_check_count", 64'(check_count), 64'd0);
        n_rst = 1'b1;
        idle_cycles(2);

        // Full equality across all 8 words: passes after 8 compare cycles.
        h = {32'h0000_0000, {7{32'hFFFF_FFFF}}};
        send(h, h, 32'hCAFE_0001, 1'b1, 8, 1'b1, ta);
        drain();

        // Early exit on word 7, hash < target.
        h = {32'h0000_0001, {7{32'hFFFF_FFFF}}};
        t = {32'h0000_0010, {7{32'h0000_0000}}};
        send(h, t, 32'hCAFE_0002, 1'b1, 1, 1'b1, ta);
        drain();

        // Word 7 equal, word 6 hash > target.
        h = {32'h0000_00AB, 32'h8000_0000, {6{32'h0000_0000}}};
        t = {32'h0000_00AB, 32'h0000_0000, {6{32'hFFFF_FFFF}}};
        send(h, t, 32'hCAFE_0003, 1'b0, 2, 1'b1, ta);
        drain();

        // Differences only in the least-significant word, both directions.
        h = {{7{32'h5555_AAAA}}, 32'h0000_0005};
        t = {{7{32'h5555_AAAA}}, 32'h0000_0004};
        send(h, t, 32'hCAFE_0004, 1'b0, 8, 1'b1, ta);
        drain();
        h = {{7{32'h5555_AAAA}}, 32'h0000_0003};
        send(h, t, 32'hCAFE_0005, 1'b1, 8, 1'b1, ta);
        drain();

        // Difference in word 3 after four equal words.
        h = {{4{32'h0000_1234}}, 32'h0000_0010, {3{32'hFFFF_FFFF}}};
        t = {{4{32'h0000_1234}}, 32'h0000_0020, {3{32'h0000_0000}}};
        send(h, t, 32'hCAFE_0006, 1'b1, 5, 1'b1, ta);
        drain();

        // hash_valid during COMPARE is ignored; next digest accepted right after DONE.
        h = {8{32'h0F0F_0F0F}};
        send(h, h, 32'h0000_0044, 1'b1, 8, 1'b1, ta);
        idle_cycles(1);
        check("busy_not_ready", 64'(hash_ready), 64'd0);
        hash_valid = 1'b1;
        hash_in    = '0;
        target     = '1;
        nonce_in   = 32'h0000_0099;
        idle_cycles(1);
        hash_valid = 1'b0;
        h = {32'h0000_0001, {7{32'hFFFF_FFFF}}};
        t = {32'h0000_0010, {7{32'h0000_0000}}};
        send(h, t, 32'h0000_0055, 1'b1, 1, 1'b1, tb);
        check("back_to_back_accept_cycle", 64'(tb), 64'(ta + 10));
        drain();

        // Flush mid-compare: no result, ready again next cycle, count unchanged.
        h = {8{32'h7777_7777}};
        send(h, h, 32'hDEAD_0001, 1'b1, 8, 1'b0, ta);
        idle_cycles(1);
        check("flush_pre_count_cycle", 64'(cyc), 64'(ta + 2));
        idle_cycles(1);
        flush = 1'b1;
        idle_cycles(1);
        flush = 1'b0;
        check("flush_ready", 64'(hash_ready), 64'd1);
        check("flush_count", 64'(check_count), 64'(cnt_model));
        idle_cycles(12);

        // flush together with hash_valid in IDLE: digest not accepted.
        hash_valid = 1'b1;
        flush      = 1'b1;
        hash_in    = '0;
        target     = '1;
        nonce_in   = 32'hDEAD_0002;
        idle_cycles(1);
        hash_valid = 1'b0;
        flush      = 1'b0;
        check("flush_valid_ready", 64'(hash_ready), 64'd1);
        idle_cycles(12);
        check("flush_valid_count", 64'(check_count), 64'(cnt_model));

        // Reset mid-compare abandons the check and clears all outputs.
        h = {8{32'h3333_3333}};
        send(h, h, 32'hDEAD_0003, 1'b1, 8, 1'b0, ta);
        idle_cycles(2);
        n_rst = 1'b0;
        idle_cycles(1);
        check("midreset_hash_ready", 64'(hash_ready), 64'd1);
        check("midreset_result_valid", 64'(result_valid), 64'd0);
        check("midreset_result_found", 64'(result_found), 64'd0);
        check("midreset_result_nonce", 64'(result_nonce), 64'd0);
        check("midreset_check_count", 64'(check_count), 64'd0);
        cnt_model  = 32'd0;
        held_found = 1'b0;
        held_nonce = 32'd0;
        n_rst = 1'b1;
        idle_cycles(12);

        // Normal check after the reset.
        h = {32'h0000_00AB, 32'h8000_0000, {6{32'h0000_0000}}};
        t = {32'h0000_00AB, 32'h0000_0000, {6{32'hFFFF_FFFF}}};
        send(h, t, 32'hBEEF_0007, 1'b0, 2, 1'b1, ta);
        drain();
        idle_cycles(3);

        $display("End of test - %0d assertions evaluated, %0d failures", asserts, fails);
        $finish;
    end

endmodule
